// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: turns load-use, branch/jump, EX-busy and bus-busy
// events into per-stage hold/flush strobes and a single-cycle PC redirect.
// Optional perf counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
    parameter int ADDR_W = 32,
    parameter int REG_W  = 5,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_W-1:0]  id_rs1_i,
    input  logic [REG_W-1:0]  id_rs2_i,
    input  logic [REG_W-1:0]  ex_rd_i,
    input  logic              ex_is_load_i,
    input  logic              jump_en_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              ex_busy_i,
    input  logic              bus_busy_i,
    output logic              hold_pc_o,
    output logic              hold_if_id_o,
    output logic              hold_id_ex_o,
    output logic              flush_if_id_o,
    output logic              flush_id_ex_o,
    output logic              jump_en_o,
    output logic [ADDR_W-1:0] jump_addr_o,
    output logic [PERF_W-1:0] stall_cnt_o,
    output logic [PERF_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {RUN, LU_BUBBLE, WAIT, REDIRECT} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pend_addr, pend_addr_nxt;
    logic              load_use;
    logic              hold_pc_c, hold_if_id_c, hold_id_ex_c;
    logic              flush_if_id_c, flush_id_ex_c;
    logic              jump_en_c;
    logic [ADDR_W-1:0] jump_addr_c;

    assign load_use = ex_is_load_i && (ex_rd_i != '0) &&
                      ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            pend_addr <= '0;
        end else begin
            state     <= state_nxt;
            pend_addr <= pend_addr_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pend_addr_nxt = pend_addr;
        hold_pc_c     = 1'b0;
        hold_if_id_c  = 1'b0;
        hold_id_ex_c  = 1'b0;
        flush_if_id_c = 1'b0;
        flush_id_ex_c = 1'b0;
        jump_en_c     = 1'b0;
        jump_addr_c   = '0;
        case (state)
            // LU_BUBBLE behaves like RUN except a second bubble is never inserted
            RUN, LU_BUBBLE: begin
                state_nxt = RUN;
                if (bus_busy_i) begin
                    hold_pc_c    = 1'b1;
                    hold_if_id_c = 1'b1;
                    hold_id_ex_c = 1'b1;
                    if (jump_en_i) begin
                        pend_addr_nxt = jump_addr_i;
                        state_nxt     = REDIRECT;
                    end else begin
                        state_nxt = WAIT;
                    end
                end else if (jump_en_i) begin
                    jump_en_c     = 1'b1;
                    jump_addr_c   = jump_addr_i;
                    flush_if_id_c = 1'b1;
                    flush_id_ex_c = 1'b1;
                end else if (ex_busy_i) begin
                    hold_pc_c    = 1'b1;
                    hold_if_id_c = 1'b1;
                    hold_id_ex_c = 1'b1;
                    state_nxt    = WAIT;
                end else if (load_use && (state == RUN)) begin
                    hold_pc_c     = 1'b1;
                    hold_if_id_c  = 1'b1;
                    flush_id_ex_c = 1'b1;
                    state_nxt     = LU_BUBBLE;
                end
            end
            WAIT: begin
                hold_pc_c    = ex_busy_i || bus_busy_i;
                hold_if_id_c = ex_busy_i || bus_busy_i;
                hold_id_ex_c = ex_busy_i || bus_busy_i;
                if (jump_en_i) begin
                    pend_addr_nxt = jump_addr_i;
                    state_nxt     = REDIRECT;
                end else if (!ex_busy_i && !bus_busy_i) begin
                    state_nxt = RUN;
                end
            end
            // Later jumps are ignored here: the older EX instruction owns the redirect
            REDIRECT: begin
                if (ex_busy_i || bus_busy_i) begin
                    hold_pc_c    = 1'b1;
                    hold_if_id_c = 1'b1;
                    hold_id_ex_c = 1'b1;
                end else begin
                    jump_en_c     = 1'b1;
                    jump_addr_c   = pend_addr;
                    flush_if_id_c = 1'b1;
                    flush_id_ex_c = 1'b1;
                    state_nxt     = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // Reset forces a bubble into both registers; flush wins over hold on a register
    assign hold_pc_o     = rst & hold_pc_c;
    assign hold_if_id_o  = rst & hold_if_id_c & ~flush_if_id_c;
    assign hold_id_ex_o  = rst & hold_id_ex_c & ~flush_id_ex_c;
    assign flush_if_id_o = ~rst | flush_if_id_c;
    assign flush_id_ex_o = ~rst | flush_id_ex_c;
    assign jump_en_o     = rst & jump_en_c;
    assign jump_addr_o   = rst ? jump_addr_c : '0;

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_W-1:0] stall_cnt, flush_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (hold_pc_o) stall_cnt <= stall_cnt + PERF_W'(1);
            if (jump_en_o) flush_cnt <= flush_cnt + PERF_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt;
    assign flush_cnt_o = flush_cnt;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed, table-driven bench for pipe_ctrl plus hand sequences for async reset
// and the perf counters (PIPE_CTRL_PERF_EN selects the expected counter values).
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_is_load, jump_en, ex_busy, bus_busy;
    logic [31:0] jump_addr;
    logic        hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, jump_en_out;
    logic [31:0] jump_addr_out, stall_cnt, flush_cnt;

    int checks = 0;
    int passes = 0;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        ld;
        logic        jen;
        logic [31:0] jaddr;
        logic        exb;
        logic        busb;
        logic [4:0]  ctrl;
        logic        jeno;
        logic [31:0] jaddro;
    } vec_t;

    localparam int NVEC = 28;
    vec_t vecs [NVEC];

    pipe_ctrl #(.ADDR_W(32), .REG_W(5), .PERF_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .ex_rd_i       (ex_rd),
        .ex_is_load_i  (ex_is_load),
        .jump_en_i     (jump_en),
        .jump_addr_i   (jump_addr),
        .ex_busy_i     (ex_busy),
        .bus_busy_i    (bus_busy),
        .hold_pc_o     (hold_pc),
        .hold_if_id_o  (hold_if_id),
        .hold_id_ex_o  (hold_id_ex),
        .flush_if_id_o (flush_if_id),
        .flush_id_ex_o (flush_id_ex),
        .jump_en_o     (jump_en_out),
        .jump_addr_o   (jump_addr_out),
        .stall_cnt_o   (stall_cnt),
        .flush_cnt_o   (flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic ld, input logic jen, input logic [31:0] jaddr,
                                input logic exb, input logic busb, input logic [4:0] ctrl,
                                input logic jeno, input logic [31:0] jaddro);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.ld = ld; v.jen = jen; v.jaddr = jaddr;
        v.exb = exb; v.busb = busb; v.ctrl = ctrl; v.jeno = jeno; v.jaddro = jaddro;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        id_rs1     = v.rs1;
        id_rs2     = v.rs2;
        ex_rd      = v.rd;
        ex_is_load = v.ld;
        jump_en    = v.jen;
        jump_addr  = v.jaddr;
        ex_busy    = v.exb;
        bus_busy   = v.busb;
    endtask

    // ctrl = {hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex}
    task automatic checkOutput(input string name, input logic [4:0] ctrl,
                               input logic jeno, input logic [31:0] jaddro);
        logic [4:0] act;
        act = {hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex};
        checks++;
        if (act === ctrl && jump_en_out === jeno && jump_addr_out === jaddro) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: ctrl=%b jen=%b addr=%h, expected ctrl=%b jen=%b addr=%h",
                     name, act, jump_en_out, jump_addr_out, ctrl, jeno, jaddro);
        end
    endtask

    task automatic checkCounters(input string name, input logic [31:0] exp_stall,
                                 input logic [31:0] exp_flush);
        checks++;
        if (stall_cnt === exp_stall && flush_cnt === exp_flush) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: stall=%0d flush=%0d, expected stall=%0d flush=%0d",
                     name, stall_cnt, flush_cnt, exp_stall, exp_flush);
        end
    endtask

    initial begin
        vec_t idle;
        logic [31:0] exp_stall, exp_flush;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0);

        // load-use, suppressed second bubble, rd=0, rs2 match, jump in bubble
        vecs[0]  = idle;
        vecs[1]  = mk(5, 0, 5, 1, 0, 0, 0, 0, 5'b11001, 0, 0);
        vecs[2]  = mk(5, 0, 5, 1, 0, 0, 0, 0, 5'b00000, 0, 0);
        vecs[3]  = idle;
        vecs[4]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 5'b00000, 0, 0);
        vecs[5]  = mk(1, 7, 7, 1, 0, 0, 0, 0, 5'b11001, 0, 0);
        vecs[6]  = mk(1, 7, 7, 1, 1, 32'h100, 0, 0, 5'b00011, 1, 32'h100);
        // jump in RUN, single cycle
        vecs[7]  = mk(0, 0, 0, 0, 1, 32'h104, 0, 0, 5'b00011, 1, 32'h104);
        vecs[8]  = idle;
        // multi-cycle EX for 4 cycles
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b11100, 0, 0);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b11100, 0, 0);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b11100, 0, 0);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b11100, 0, 0);
        vecs[13] = idle;
        vecs[14] = idle;
        // jump under bus busy, second jump ignored
        vecs[15] = mk(0, 0, 0, 0, 1, 32'h200, 0, 1, 5'b11100, 0, 0);
        vecs[16] = mk(0, 0, 0, 0, 1, 32'h300, 0, 1, 5'b11100, 0, 0);
        vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 1, 5'b11100, 0, 0);
        vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00011, 1, 32'h200);
        vecs[19] = idle;
        // jump arriving in WAIT
        vecs[20] = mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b11100, 0, 0);
        vecs[21] = mk(0, 0, 0, 0, 1, 32'h400, 1, 0, 5'b11100, 0, 0);
        vecs[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00011, 1, 32'h400);
        vecs[23] = idle;
        // priority: bus busy and ex busy beat load-use
        vecs[24] = mk(3, 0, 3, 1, 0, 0, 0, 1, 5'b11100, 0, 0);
        vecs[25] = idle;
        vecs[26] = mk(3, 0, 3, 1, 0, 0, 1, 0, 5'b11100, 0, 0);
        vecs[27] = idle;

        // reset values with a jump request present
        rst = 1'b0;
        applyStimulus(mk(0, 0, 0, 0, 1, 32'hABC, 0, 0, 5'b00000, 0, 0));
        #3 checkOutput("reset_outputs", 5'b00011, 1'b0, 32'h0);
        @(negedge clk);
        applyStimulus(idle);
        rst = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #2 checkOutput($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].jeno, vecs[i].jaddro);
        end

`ifdef PIPE_CTRL_PERF_EN
        exp_stall = 32'd13;
        exp_flush = 32'd4;
`else
        exp_stall = 32'd0;
        exp_flush = 32'd0;
`endif
        @(negedge clk);
        applyStimulus(idle);
        #2 checkCounters("perf_after_table", exp_stall, exp_flush);

        // async reset in the middle of REDIRECT discards the pending jump
        @(negedge clk);
        applyStimulus(mk(0, 0, 0, 0, 1, 32'h500, 0, 1, 5'b00000, 0, 0));
        #2 checkOutput("redir_enter", 5'b11100, 1'b0, 32'h0);
        @(negedge clk);
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 0, 0));
        #2 checkOutput("redir_hold", 5'b11100, 1'b0, 32'h0);
        #1 rst = 1'b0;
        #1 checkOutput("async_reset_now", 5'b00011, 1'b0, 32'h0);
        @(negedge clk);
        applyStimulus(idle);
        @(negedge clk);
        rst = 1'b1;
        #2 checkOutput("post_reset_0", 5'b00000, 1'b0, 32'h0);
        checkCounters("perf_after_reset", 32'd0, 32'd0);
        @(negedge clk);
        #2 checkOutput("post_reset_1", 5'b00000, 1'b0, 32'h0);
        @(negedge clk);
        #2 checkOutput("post_reset_2", 5'b00000, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
